// File: rtl/axi_burst_ram.sv
// AXI4 burst slave in front of a single-port byte-writable RAM.
// One burst in flight; AW/AR collisions are arbitrated round-robin.
module axi_burst_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic              rr_q;
  logic              rd_done_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [1:0]        rresp_q;
  logic              zero_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              oor;
  logic              wrap_bad;
  logic              beat_bad;
  logic              last_beat;
  logic              grant_w;
  logic              grant_r;
  logic              w_fire;
  logic              we;
  logic              re;
  logic              r_fire;
  logic              unused_wlast;

  // termination is by beat count only
  assign unused_wlast = s_axi_wlast;

  assign bytes     = ADDR_W'(1) << size_q;
  assign incr      = addr_q + bytes;
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q)
                     - ADDR_W'(1);

  always_comb begin
    next_addr = incr;
    unique case (1'b1)
      burst_q == 2'b00: next_addr = addr_q;
      burst_q == 2'b10: next_addr = (addr_q & ~wrap_mask)
                                  | (incr & wrap_mask);
      default:          next_addr = incr;
    endcase
  end

  assign word_idx  = addr_q >> OFF_W;
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign oor       = word_idx >= ADDR_W'(DEPTH);
  assign wrap_bad  = (burst_q == 2'b10) &&
                     !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
  assign beat_bad  = oor || wrap_bad;
  assign last_beat = cnt_q == len_q;

  // rr_q set means read holds priority on the next collision
  assign grant_w = s_axi_awvalid && (!s_axi_arvalid || !rr_q);
  assign grant_r = s_axi_arvalid && !grant_w;

  assign s_axi_awready = (state_q == IDLE) && grant_w;
  assign s_axi_arready = (state_q == IDLE) && grant_r;
  assign s_axi_wready  = state_q == WDATA;
  assign s_axi_bvalid  = state_q == WRESP;
  assign s_axi_bresp   = {err_q, 1'b0};

  assign w_fire = s_axi_wready && s_axi_wvalid;
  assign we     = w_fire && !beat_bad;
  // issue a read only when the output slot is free or draining
  assign re     = (state_q == RDATA) && !rd_done_q &&
                  (!rvalid_q || s_axi_rready);
  assign r_fire = rvalid_q && s_axi_rready;

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = zero_q ? '0 : mem_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_w)      state_d = WDATA;
        else if (grant_r) state_d = RDATA;
      end
      WDATA: if (w_fire && last_beat) state_d = WRESP;
      WRESP: if (s_axi_bready) state_d = IDLE;
      RDATA: if (r_fire && rlast_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rr_q      <= 1'b0;
      rd_done_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (s_axi_awready) begin
        addr_q  <= s_axi_awaddr;
        len_q   <= s_axi_awlen;
        size_q  <= s_axi_awsize;
        burst_q <= s_axi_awburst;
        cnt_q   <= '0;
        err_q   <= 1'b0;
        if (s_axi_arvalid) rr_q <= 1'b1;
      end else if (s_axi_arready) begin
        addr_q    <= s_axi_araddr;
        len_q     <= s_axi_arlen;
        size_q    <= s_axi_arsize;
        burst_q   <= s_axi_arburst;
        cnt_q     <= '0;
        rd_done_q <= 1'b0;
        if (s_axi_awvalid) rr_q <= 1'b0;
      end
      if (w_fire) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= next_addr;
        if (beat_bad) err_q <= 1'b1;
      end
      if (re) begin
        cnt_q     <= cnt_q + 8'd1;
        addr_q    <= next_addr;
        rd_done_q <= last_beat;
        rvalid_q  <= 1'b1;
        rlast_q   <= last_beat;
        rresp_q   <= beat_bad ? 2'b10 : 2'b00;
        zero_q    <= beat_bad;
      end else if (r_fire) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  // contents survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b])
          mem[mem_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (re) mem_q <= mem[mem_idx];
  end

endmodule

// File: tb/tb_axi_burst_ram.sv
// Directed bench for axi_burst_ram: bursts, strobes, wrap,
// range errors, arbitration, back-pressure and reset.
module tb_axi_burst_ram;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst;
  logic        s_axi_awvalid, s_axi_awready;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wb [16];
  logic [3:0]  sb [16];
  logic [31:0] rd_d [16];
  logic [1:0]  rd_r [16];
  logic        rd_l [16];
  int          got;
  logic [1:0]  resp;

  always #5 clock = ~clock;

  axi_burst_ram dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic aw_hs(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] bt);
    int n = 0;
    s_axi_awaddr = a; s_axi_awlen = len;
    s_axi_awsize = 3'd2; s_axi_awburst = bt; s_axi_awvalid = 1'b1;
    #1;
    while (!s_axi_awready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk("aw_hs", s_axi_awready, 1'b1);
    @(negedge clock);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beats(input int len);
    for (int i = 0; i <= len; i++) begin
      int n = 0;
      s_axi_wdata = wb[i]; s_axi_wstrb = sb[i];
      s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
      #1;
      while (!s_axi_wready && n < 50) begin
        @(negedge clock); #1; n++;
      end
      if (n >= 50) chk("w_hs", s_axi_wready, 1'b1);
      @(negedge clock);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
  endtask

  task automatic b_wait(output logic [1:0] r);
    int n = 0;
    s_axi_bready = 1'b1;
    #1;
    while (!s_axi_bvalid && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk("b_hs", s_axi_bvalid, 1'b1);
    r = s_axi_bresp;
    @(negedge clock);
    s_axi_bready = 1'b0;
  endtask

  task automatic ar_hs(input logic [31:0] a, input logic [7:0] len,
                       input logic [1:0] bt);
    int n = 0;
    s_axi_araddr = a; s_axi_arlen = len;
    s_axi_arsize = 3'd2; s_axi_arburst = bt; s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk("ar_hs", s_axi_arready, 1'b1);
    @(negedge clock);
    s_axi_arvalid = 1'b0;
  endtask

  // mode 1 drives RREADY with the repeating pattern 1,0,0,1
  task automatic r_collect(input int len, input bit mode);
    int cyc = 1;
    int k = 0;
    int first = -1;
    bit done = 0;
    bit hold = 0;
    logic [34:0] hv = '0;
    logic [3:0] pat = 4'b1001;
    got = 0;
    while (!done && cyc < 200) begin
      s_axi_rready = mode ? pat[k % 4] : 1'b1;
      #1;
      if (hold)
        chk("r_hold", {s_axi_rdata, s_axi_rresp, s_axi_rlast}, hv);
      if (s_axi_rvalid && first < 0) first = cyc;
      hold = s_axi_rvalid && !s_axi_rready;
      hv = {s_axi_rdata, s_axi_rresp, s_axi_rlast};
      if (s_axi_rvalid && s_axi_rready && got < 16) begin
        rd_d[got] = s_axi_rdata;
        rd_r[got] = s_axi_rresp;
        rd_l[got] = s_axi_rlast;
        got++;
        if (s_axi_rlast) done = 1;
      end
      k++;
      @(negedge clock);
      cyc++;
    end
    s_axi_rready = 1'b0;
    chk("r_lat", 64'(first), 64'd2);
    chk("r_beats", 64'(got), 64'(len + 1));
  endtask

  task automatic write1(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [1:0] r);
    wb[0] = d; sb[0] = s;
    aw_hs(a, 8'd0, 2'b01);
    w_beats(0);
    b_wait(r);
  endtask

  task automatic read1(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] rr, input string tag);
    ar_hs(a, 8'd0, 2'b01);
    r_collect(0, 1'b0);
    chk({tag, "_d"}, rd_d[0], d);
    chk({tag, "_r"}, rd_r[0], rr);
  endtask

  initial begin
    logic [31:0] exp4 [4];
    reset = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_rlast", s_axi_rlast, 1'b0);
    chk("rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
    reset = 1'b0;
    @(negedge clock);

    // INCR write 1..4 then read back
    for (int i = 0; i < 4; i++) begin
      wb[i] = 32'(i + 1); sb[i] = 4'hF;
    end
    aw_hs(32'h10, 8'd3, 2'b01);
    w_beats(3);
    b_wait(resp);
    chk("incr_bresp", resp, 2'b00);
    ar_hs(32'h10, 8'd3, 2'b01);
    r_collect(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("incr_d", rd_d[i], 32'(i + 1));
      chk("incr_r", rd_r[i], 2'b00);
      chk("incr_last", rd_l[i], i == 3);
    end

    // WRAP from 0x18: 0x18,0x1C,0x10,0x14 hold 3,4,1,2
    exp4[0] = 32'd3; exp4[1] = 32'd4; exp4[2] = 32'd1; exp4[3] = 32'd2;
    ar_hs(32'h18, 8'd3, 2'b10);
    r_collect(3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_d", rd_d[i], exp4[i]);
      chk("wrap_last", rd_l[i], i == 3);
    end

    // WRAP with illegal len=2: error, nothing written
    for (int i = 0; i < 3; i++) begin
      wb[i] = 32'hFFFF_FFFF; sb[i] = 4'hF;
    end
    aw_hs(32'h10, 8'd2, 2'b10);
    w_beats(2);
    b_wait(resp);
    chk("wrapbad_bresp", resp, 2'b10);
    read1(32'h10, 32'd1, 2'b00, "wrapbad_mem");

    // byte strobes
    write1(32'h0, 32'h0, 4'hF, resp);
    write1(32'h0, 32'hAABB_CCDD, 4'h5, resp);
    chk("strb_bresp", resp, 2'b00);
    read1(32'h0, 32'h00BB_00DD, 2'b00, "strb");

    // word index DEPTH is out of range and must not alias word 0
    write1(32'h0, 32'h1122_3344, 4'hF, resp);
    write1(32'h1000, 32'hDEAD_BEEF, 4'hF, resp);
    chk("oor_bresp", resp, 2'b10);
    read1(32'h1000, 32'h0, 2'b10, "oor_rd");
    read1(32'h0, 32'h1122_3344, 2'b00, "oor_mem");

    // first collision: write wins, then the pending read
    s_axi_awaddr = 32'h80; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h80; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    #1;
    chk("col1_awready", s_axi_awready, 1'b1);
    chk("col1_arready", s_axi_arready, 1'b0);
    @(negedge clock);
    s_axi_awvalid = 1'b0;
    wb[0] = 32'h55; sb[0] = 4'hF;
    w_beats(0);
    b_wait(resp);
    ar_hs(32'h80, 8'd0, 2'b01);
    r_collect(0, 1'b0);
    chk("col1_rd", rd_d[0], 32'h55);

    // second collision: read wins
    s_axi_awaddr = 32'h84; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h80; s_axi_arvalid = 1'b1;
    #1;
    chk("col2_arready", s_axi_arready, 1'b1);
    chk("col2_awready", s_axi_awready, 1'b0);
    @(negedge clock);
    s_axi_arvalid = 1'b0;
    r_collect(0, 1'b0);
    chk("col2_rd", rd_d[0], 32'h55);
    wb[0] = 32'h66; sb[0] = 4'hF;
    aw_hs(32'h84, 8'd0, 2'b01);
    w_beats(0);
    b_wait(resp);
    read1(32'h84, 32'h66, 2'b00, "col2_wr");

    // len=7 read under RREADY back-pressure
    for (int i = 0; i < 8; i++) begin
      wb[i] = 32'h100 + 32'(i); sb[i] = 4'hF;
    end
    aw_hs(32'h40, 8'd7, 2'b01);
    w_beats(7);
    b_wait(resp);
    ar_hs(32'h40, 8'd7, 2'b01);
    r_collect(7, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("bp_d", rd_d[i], 32'h100 + 32'(i));
      chk("bp_last", rd_l[i], i == 7);
    end

    // reset in the middle of a read burst
    ar_hs(32'h40, 8'd7, 2'b01);
    s_axi_rready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    s_axi_rready = 1'b0;
    chk("rstmid_rvalid", s_axi_rvalid, 1'b0);
    chk("rstmid_rlast", s_axi_rlast, 1'b0);
    read1(32'h44, 32'h101, 2'b00, "rstmid_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
